sensing_spi_master: RTL

SENSING_SPI_MASTER -- requirements
Module: sensing_spi_master

---
 rtl/sensing_spi_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sensing_spi_master.sv
// rtl/sensing_spi_master.sv - SPI mode-0 master that reads one 104-bit sensing frame per request
// Optional auto-trigger from adc_data_ready is built when SENSING_SPI_AUTO_TRIG_EN is defined.
module sensing_spi_master #(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SENSING_SPI_AUTO_TRIG_EN
    input  logic        adc_data_ready,
`endif
    output logic        busy,
    output logic        done,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic [15:0] adc_ch0,
    output logic [15:0] adc_ch1,
    output logic [15:0] adc_ch2,
    output logic [15:0] adc_ch3,
    output logic [31:0] sample_cnt,
    output logic        stale
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [7:0]  CMD      = 8'h80;
    localparam logic [6:0]  LAST_BIT = 7'd103;
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [6:0]         bit_q, bit_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         tx_q, tx_d;
    logic [95:0]        rx_q, rx_d;
    logic [3:0][15:0]   ch_q, ch_d;
    logic [31:0]        scnt_q, scnt_d;
    logic               stale_q, stale_d;
    logic               first_q, first_d;
    logic               trig;

`ifdef SENSING_SPI_AUTO_TRIG_EN
    // Two synchronizer flops plus one history flop for rising-edge detection.
    logic [2:0] rdy_q;
    always_ff @(posedge clk) begin
        if (!rst_n) rdy_q <= 3'b000;
        else        rdy_q <= {rdy_q[1:0], adc_data_ready};
    end
    assign trig = start | (rdy_q[1] & ~rdy_q[2]);
`else
    assign trig = start;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ch_d    = ch_q;
        scnt_d  = scnt_q;
        stale_d = stale_q;
        first_d = first_q;
        if (done_q) busy_d = 1'b0;
        case (state_q)
            IDLE: begin
                // busy_q still high in the done cycle, so a start there is ignored.
                if (trig && !busy_q) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = CMD;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_M1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (sck_q && cnt_q == '0) rx_d = {rx_q[94:0], spi_miso};
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_M1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    ch_d[0] = rx_q[95:80];
                    ch_d[1] = rx_q[79:64];
                    ch_d[2] = rx_q[63:48];
                    ch_d[3] = rx_q[47:32];
                    scnt_d  = rx_q[31:0];
                    stale_d = !first_q && (rx_q[31:0] == scnt_q);
                    first_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            ch_q    <= '0;
            scnt_q  <= '0;
            stale_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ch_q    <= ch_d;
            scnt_q  <= scnt_d;
            stale_q <= stale_d;
            first_q <= first_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = tx_q[7];
    assign spi_cs_n   = cs_n_q;
    assign adc_ch0    = ch_q[0];
    assign adc_ch1    = ch_q[1];
    assign adc_ch2    = ch_q[2];
    assign adc_ch3    = ch_q[3];
    assign sample_cnt = scnt_q;
    assign stale      = stale_q;
endmodule
